// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter.
//   state_e  : arbiter FSM encoding (ST_IDLE, ST_GRANT_I, ST_GRANT_D)
//   GNT_I/D  : encoding of the last-grant register
//   STARVE_W : width of the starvation counter (STARVE_MAX range 1..15)
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin instead of D priority).
package mem_arb_pkg;

   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } state_e;

   // Reset value of last-grant is 0, so round-robin starts with I.
   localparam logic GNT_D = 1'b0;
   localparam logic GNT_I = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
// Ports:
//   i_req_i, d_req_i    : raw requests
//   i_mask_i, d_mask_i  : suppress a request whose ack is currently high
//   starve_hit_i        : I has waited STARVE_MAX D grants (priority mode)
//   last_gnt_i          : port granted last (round-robin mode)
//   gnt_d_o             : 1 = D wins, 0 = I wins (meaningful with gnt_valid_o)
//   gnt_valid_o         : at least one unmasked request pending
// Macro ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed D priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic i_mask_i,
   input  logic d_mask_i,
   input  logic starve_hit_i,
   input  logic last_gnt_i,
   output logic gnt_d_o,
   output logic gnt_valid_o
);

   logic i_pend;
   logic d_pend;

   assign i_pend      = i_req_i & ~i_mask_i;
   assign d_pend      = d_req_i & ~d_mask_i;
   assign gnt_valid_o = i_pend | d_pend;

`ifdef ARB_ROUND_ROBIN_EN
   logic unused_starve_hit;
   assign unused_starve_hit = starve_hit_i;

   // On contention grant the port that did not win last time.
   always_comb begin
      gnt_d_o = d_pend;
      if (i_pend && d_pend) begin
         gnt_d_o = (last_gnt_i == GNT_I);
      end
   end
`else
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt_i;

   // D wins unless I has been starved long enough.
   assign gnt_d_o = d_pend & ~(i_pend & starve_hit_i);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between fetch (I) and
// load/store (D) requesters.
// Ports:
//   Clk, Reset                  : clock, async active-low reset
//   i_req/i_addr -> i_ack/i_rdata : fetch port (level req, 1-cycle ack)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : load/store port
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata : memory side
//   grant_d                     : D transaction outstanding
// Macro ARB_ROUND_ROBIN_EN: round-robin on contention, starvation guard removed.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant_d
);

   state_e              state_q,     state_d;
   logic                mem_req_q,   mem_req_d;
   logic                mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                gnt_d_q,     gnt_d_d;
   logic                i_ack_q,     i_ack_d;
   logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
   logic                d_ack_q,     d_ack_d;
   logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
   logic                last_gnt_q,  last_gnt_d;

   logic pick_gnt_d;
   logic pick_valid;
   logic starve_hit;
   logic arb_go;

   mem_arb_pick u_pick (
      .i_req_i      (i_req),
      .d_req_i      (d_req),
      .i_mask_i     (i_ack_q),
      .d_mask_i     (d_ack_q),
      .starve_hit_i (starve_hit),
      .last_gnt_i   (last_gnt_q),
      .gnt_d_o      (pick_gnt_d),
      .gnt_valid_o  (pick_valid)
   );

   // The ack cycle doubles as a bus turnaround: no grant while an ack is on
   // the wire, so a requester holding req through its ack keeps its place.
   assign arb_go = (state_q == ST_IDLE) & pick_valid & ~(i_ack_q | d_ack_q);

`ifdef ARB_ROUND_ROBIN_EN
   localparam int unsigned unused_starve_max = STARVE_MAX;
   assign starve_hit = 1'b0;
`else
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

   assign starve_hit = (starve_cnt_q >= STARVE_LIM);

   // Count D grants taken while I waits; any I grant or idle I clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == ST_IDLE) begin
         if (!i_req) begin
            starve_cnt_d = '0;
         end else if (arb_go) begin
            if (!pick_gnt_d) begin
               starve_cnt_d = '0;
            end else if (!starve_hit) begin
               starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gnt_d_d     = gnt_d_q;
      i_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_ack_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      last_gnt_d  = last_gnt_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_go) begin
               mem_req_d = 1'b1;
               gnt_d_d   = pick_gnt_d;
               if (pick_gnt_d) begin
                  state_d     = ST_GRANT_D;
                  last_gnt_d  = GNT_D;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  state_d     = ST_GRANT_I;
                  last_gnt_d  = GNT_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = DATA_W'(0);
               end
            end
         end
         ST_GRANT_I: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = mem_rdata;
            end
         end
         ST_GRANT_D: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               gnt_d_d   = 1'b0;
               d_ack_d   = 1'b1;
               d_rdata_d = mem_we_q ? DATA_W'(0) : mem_rdata;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            gnt_d_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gnt_d_q     <= 1'b0;
         i_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_ack_q     <= 1'b0;
         d_rdata_q   <= '0;
         last_gnt_q  <= GNT_D;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         gnt_d_q     <= gnt_d_d;
         i_ack_q     <= i_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_ack_q     <= d_ack_d;
         d_rdata_q   <= d_rdata_d;
         last_gnt_q  <= last_gnt_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign grant_d   = gnt_d_q;
   assign i_ack     = i_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected acks
// and grants; negedge monitors pop and compare. Honours ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned SMAX = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_req, mem_we, grant_d;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .Clk(Clk), .Reset(Reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .grant_d(grant_d)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
   } grant_t;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] exp_i_q[$], exp_d_q[$];
   grant_t      exp_g_q[$];
   bit          order_q[$];
   bit          rec_order = 0;
   int          i_issued = 0, d_issued = 0, i_acked = 0, d_acked = 0;

   // memory responder controls
   int lat_mode = -1;
   int cur_lat = 0, wait_cnt = 0;
   bit acked = 0, spurious = 0;

   // reference arbitration state
   int          m_cnt = 0;
   bit          m_last_i = 0;
   bit          prev_mreq = 0, prev_iack = 0, prev_dack = 0, win_d;
   grant_t      g;
   logic [31:0] held_addr;
   logic        held_we;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C02_0004;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: ack cur_lat cycles after mem_req is first seen.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge Clk);
         mem_ack = 1'b0;
         if (!Reset || !mem_req) begin
            acked    = 0;
            wait_cnt = 0;
            cur_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            if (Reset && spurious) begin
               mem_ack   = 1'b1;
               mem_rdata = $urandom;
               spurious  = 0;
            end
         end else if (!acked) begin
            if (wait_cnt >= cur_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_read(mem_addr);
               acked     = 1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Monitor: acks, grants, and the reference arbitration decision.
   always @(negedge Clk) begin
      if (!Reset) begin
         exp_g_q.delete();
         m_cnt = 0; m_last_i = 0; prev_mreq = 0; prev_iack = 0; prev_dack = 0;
      end else begin
         if (i_ack) begin
            i_acked++;
            if (prev_iack) fail_now("i_ack_width");
            if (exp_i_q.size() == 0) fail_now("i_ack_unexpected");
            else check("i_rdata", 64'(i_rdata), 64'(exp_i_q.pop_front()));
         end
         if (d_ack) begin
            d_acked++;
            if (prev_dack) fail_now("d_ack_width");
            if (exp_d_q.size() == 0) fail_now("d_ack_unexpected");
            else check("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
         end
         if (mem_req && !prev_mreq) begin
            if (exp_g_q.size() == 0) fail_now("grant_unexpected");
            else begin
               g = exp_g_q.pop_front();
               check("grant_d", 64'(grant_d), 64'(g.is_d));
               check("mem_addr", 64'(mem_addr), 64'(g.addr));
               check("mem_we", 64'(mem_we), 64'(g.we));
               if (g.we) check("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
            end
            if (rec_order && order_q.size() < 10) order_q.push_back(grant_d);
            held_addr = mem_addr;
            held_we   = mem_we;
         end else if (mem_req) begin
            check("mem_addr_hold", 64'(mem_addr), 64'(held_addr));
            check("mem_we_hold", 64'(mem_we), 64'(held_we));
         end
         // Decide what the next edge should grant from the pending requests.
         if (!mem_req && !i_ack && !d_ack && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d    = (i_req && d_req) ? m_last_i : d_req;
            m_last_i = !win_d;
`else
            win_d = (i_req && d_req) ? (m_cnt < SMAX) : d_req;
            if (win_d && i_req) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : m_cnt;
            else                m_cnt = 0;
`endif
            if (win_d) exp_g_q.push_back('{1'b1, d_addr, d_we, d_wdata});
            else       exp_g_q.push_back('{1'b0, i_addr, 1'b0, 32'h0});
         end else if (!mem_req && !i_req) begin
            m_cnt = 0;
         end
         prev_mreq = mem_req;
         prev_iack = i_ack;
         prev_dack = d_ack;
      end
   end

   task automatic do_req(input bit is_d, input logic [31:0] addr, input bit we,
                         input logic [31:0] wd);
      bit got;
      got = 0;
      if (is_d) begin
         d_we = we; d_addr = addr; d_wdata = wd;
         exp_d_q.push_back(we ? 32'h0 : mem_read(addr));
         d_issued++;
         d_req = 1'b1;
      end else begin
         i_addr = addr;
         exp_i_q.push_back(mem_read(addr));
         i_issued++;
         i_req = 1'b1;
      end
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge Clk);
         got = is_d ? d_ack : i_ack;
      end
      if (!got) fail_now(is_d ? "d_ack_timeout" : "i_ack_timeout");
      @(posedge Clk);
      #1;
      if (is_d) d_req = 1'b0;
      else      i_req = 1'b0;
   endtask

   task automatic pulse_reset();
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   bit exp_order[10];

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      bit got;
      Reset = 1'b0;
      i_req = 0; d_req = 0; d_we = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_i_ack", 64'(i_ack), 64'h0);
      check("rst_d_ack", 64'(d_ack), 64'h0);
      check("rst_mem_req", 64'(mem_req), 64'h0);
      check("rst_mem_we", 64'(mem_we), 64'h0);
      check("rst_mem_addr", 64'(mem_addr), 64'h0);
      check("rst_grant_d", 64'(grant_d), 64'h0);
      check("rst_i_rdata", 64'(i_rdata), 64'h0);
      check("rst_d_rdata", 64'(d_rdata), 64'h0);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // lone fetch, then store
      lat_mode = 2;
      do_req(0, 32'h40, 0, 32'h0);
      do_req(1, 32'h100, 1, 32'hDEAD_BEEF);
      check("store_d_rdata_hold", 64'(d_rdata), 64'h0);
      check("fetch_i_rdata_hold", 64'(i_rdata), 64'h8C02_0004);
      check("d_ack_count_after_fetch", 64'(d_acked), 64'd1);

      // contention from a fresh reset, zero-wait memory
      pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
      lat_mode = 0;
      order_q.delete();
      rec_order = 1;
      fork
         begin
            for (int n = 0; order_q.size() < 10 && n < 20; n++)
               do_req(0, 32'h1000 + 32'(n * 4), 0, 32'h0);
         end
         begin
            for (int n = 0; order_q.size() < 10 && n < 20; n++)
               do_req(1, 32'h2000 + 32'(n * 4), 0, 32'h0);
         end
      join
      rec_order = 0;
      check("order_len", 64'(order_q.size()), 64'd10);
      for (int k = 0; k < 10 && k < order_q.size(); k++)
         check($sformatf("order_%0d", k), 64'(order_q[k]), 64'(exp_order[k]));

      // reset while a load waits on a stalled memory
      lat_mode = 50;
      d_addr = 32'h300; d_we = 1'b0; d_wdata = 32'h0;
      d_req = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge Clk);
         got = mem_req;
      end
      if (!got) fail_now("t5_mem_req_timeout");
      #2;
      Reset = 1'b0;
      #1;
      check("t5_mem_req_async", 64'(mem_req), 64'h0);
      check("t5_grant_d_async", 64'(grant_d), 64'h0);
      d_req = 1'b0;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      lat_mode = 1;
      do_req(0, 32'h44, 0, 32'h0);

      // spurious mem_ack while idle
      spurious = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         check("t6_i_ack", 64'(i_ack), 64'h0);
         check("t6_d_ack", 64'(d_ack), 64'h0);
         check("t6_mem_req", 64'(mem_req), 64'h0);
      end
      @(posedge Clk);
      #1;
      // back-to-back re-requests
      do_req(0, 32'h200, 0, 32'h0);
      do_req(0, 32'h204, 0, 32'h0);
      do_req(1, 32'h208, 0, 32'h0);
      do_req(1, 32'h20C, 1, 32'h1234_5678);
      check("b2b_i_q_empty", 64'(exp_i_q.size()), 64'd0);
      check("b2b_d_q_empty", 64'(exp_d_q.size()), 64'd0);

      // random traffic
      lat_mode = -1;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               gap = $urandom_range(0, 3);
               if (gap > 0) begin
                  repeat (gap) @(posedge Clk);
                  #1;
               end
               do_req(0, 32'($urandom_range(0, 1023)) << 2, 0, 32'h0);
            end
         end
         begin
            for (int n = 0; n < 40; n++) begin
               int dgap;
               dgap = $urandom_range(0, 3);
               if (dgap > 0) begin
                  repeat (dgap) @(posedge Clk);
                  #1;
               end
               do_req(1, 32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
                      32'($urandom));
            end
         end
      join

      repeat (5) @(posedge Clk);
      #1;
      check("end_i_q_empty", 64'(exp_i_q.size()), 64'd0);
      check("end_d_q_empty", 64'(exp_d_q.size()), 64'd0);
      check("end_g_q_empty", 64'(exp_g_q.size()), 64'd0);
      check("end_i_acks", 64'(i_acked), 64'(i_issued));
      check("end_d_acks", 64'(d_acked), 64'(d_issued));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
